// File: rtl/fruit_round_scheduler.sv
// Fruit-slicing round sequencer: picks a fruit, times its display window, judges
// slice vs. miss from the mic frequency, and keeps score and lives.
module fruit_round_scheduler #(
  parameter logic [3:0]  GAME_STATE     = 4'b0100,
  parameter logic [3:0]  MENU_STATE     = 4'b0000,
  parameter logic [11:0] FREQ_THRESHOLD = 12'd450,
  parameter int          SHOW_CYCLES    = 2000,
  parameter int          SLICED_CYCLES  = 250,
  parameter int          MAX_LIVES      = 3,
  parameter logic [6:0]  WIN_SCORE      = 7'd99
) (
  input  logic        single_pulse_clk,
  input  logic        rst_n,
  input  logic [3:0]  state,
  input  logic        btnC,
  input  logic [11:0] frequency,
  input  logic [11:0] raw_mic_data,
  output logic [5:0]  fruit_en,
  output logic [6:0]  score,
  output logic [1:0]  lives,
  output logic        slice_pulse,
  output logic        game_over
);

  localparam int TMAX    = (SHOW_CYCLES > SLICED_CYCLES) ? SHOW_CYCLES : SLICED_CYCLES;
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TIMER_W-1:0] SHOW_LAST   = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SLICED_LAST = TIMER_W'(SLICED_CYCLES - 1);
  localparam logic [1:0]         LIVES_INIT  = 2'(MAX_LIVES);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_SHOW, S_SLICED, S_MISS, S_OVER
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         kind_q, kind_d;
  logic [5:0]         fruit_en_d;
  logic [6:0]         score_d;
  logic [1:0]         lives_d;
  logic               slice_pulse_d;
  logic               game_over_d;

  function automatic logic [6:0] sat_inc(input logic [6:0] s);
    return (s >= WIN_SCORE) ? WIN_SCORE : s + 7'd1;
  endfunction

  // Sprite layout pairs each fruit with its sliced image in the next bit up.
  function automatic logic [5:0] sprite(input logic [1:0] k, input logic sliced);
    return 6'(6'd1 << (2 * int'(k) + int'(sliced)));
  endfunction

  always_ff @(posedge single_pulse_clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      timer_q     <= '0;
      kind_q      <= '0;
      fruit_en    <= '0;
      score       <= '0;
      lives       <= LIVES_INIT;
      slice_pulse <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      timer_q     <= timer_d;
      kind_q      <= kind_d;
      fruit_en    <= fruit_en_d;
      score       <= score_d;
      lives       <= lives_d;
      slice_pulse <= slice_pulse_d;
      game_over   <= game_over_d;
    end
  end

  always_comb begin
    fsm_d         = fsm_q;
    timer_d       = timer_q;
    kind_d        = kind_q;
    fruit_en_d    = fruit_en;
    score_d       = score;
    lives_d       = lives;
    slice_pulse_d = slice_pulse;
    game_over_d   = game_over;

    if (state == MENU_STATE) begin
      fsm_d         = S_IDLE;
      timer_d       = '0;
      fruit_en_d    = '0;
      score_d       = '0;
      lives_d       = LIVES_INIT;
      slice_pulse_d = 1'b0;
      game_over_d   = 1'b0;
    end else if (state == GAME_STATE) begin
      slice_pulse_d = 1'b0;
      // Quit request overrides any slice or miss judged in the same tick.
      if (btnC && (fsm_q inside {S_PICK, S_SHOW, S_SLICED, S_MISS})) begin
        fsm_d       = S_OVER;
        timer_d     = '0;
        fruit_en_d  = '0;
        game_over_d = 1'b1;
      end else begin
        case (fsm_q)
          S_IDLE: fsm_d = S_PICK;
          S_PICK: begin
            kind_d     = 2'(raw_mic_data % 12'd3);
            timer_d    = '0;
            fruit_en_d = '0;
            fsm_d      = S_SHOW;
          end
          S_SHOW: begin
            if (frequency > FREQ_THRESHOLD) begin
              fruit_en_d    = sprite(kind_q, 1'b1);
              score_d       = sat_inc(score);
              slice_pulse_d = 1'b1;
              timer_d       = '0;
              fsm_d         = S_SLICED;
            end else begin
              fruit_en_d = sprite(kind_q, 1'b0);
              timer_d    = timer_q + TIMER_W'(1);
              if (timer_q == SHOW_LAST) begin
                timer_d = '0;
                fsm_d   = S_MISS;
              end
            end
          end
          S_SLICED: begin
            timer_d = timer_q + TIMER_W'(1);
            if (timer_q == SLICED_LAST) begin
              timer_d = '0;
              if (score == WIN_SCORE) begin
                fruit_en_d  = '0;
                game_over_d = 1'b1;
                fsm_d       = S_OVER;
              end else begin
                fsm_d = S_PICK;
              end
            end
          end
          S_MISS: begin
            fruit_en_d = '0;
            lives_d    = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            if (lives <= 2'd1) begin
              game_over_d = 1'b1;
              fsm_d       = S_OVER;
            end else begin
              fsm_d = S_PICK;
            end
          end
          S_OVER: begin
            fruit_en_d  = '0;
            game_over_d = 1'b1;
          end
          default: fsm_d = S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fruit_round_scheduler.sv
// Bench for fruit_round_scheduler: directed game scenarios, a round-level
// reference model compared every cycle, and hand-computed literal expectations.
module tb_fruit_round_scheduler;

  localparam int SHOW   = 8;
  localparam int SLICED = 4;
  localparam int WIN    = 99;

  localparam int M_IDLE = 0, M_PICK = 1, M_SHOW = 2, M_SLICED = 3, M_MISS = 4, M_OVER = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  state;
  logic        btnC;
  logic [11:0] frequency;
  logic [11:0] raw_mic_data;
  logic [5:0]  fruit_en;
  logic [6:0]  score;
  logic [1:0]  lives;
  logic        slice_pulse;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  fruit_round_scheduler #(
    .GAME_STATE(4'b0100), .MENU_STATE(4'b0000), .FREQ_THRESHOLD(12'd450),
    .SHOW_CYCLES(SHOW), .SLICED_CYCLES(SLICED), .MAX_LIVES(3), .WIN_SCORE(7'd99)
  ) dut (
    .single_pulse_clk(clk), .rst_n(rst_n), .state(state), .btnC(btnC),
    .frequency(frequency), .raw_mic_data(raw_mic_data), .fruit_en(fruit_en),
    .score(score), .lives(lives), .slice_pulse(slice_pulse), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model: game rules stepped once per tick with plain integers.
  int         m_mode, m_age, m_kind, m_score, m_lives;
  logic [5:0] m_fe;
  bit         m_pulse, m_over;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_age <= 0; m_kind <= 0; m_fe <= '0;
      m_score <= 0; m_lives <= 3; m_pulse <= 1'b0; m_over <= 1'b0;
    end else if (state == 4'b0000) begin
      m_mode <= M_IDLE; m_age <= 0; m_fe <= '0;
      m_score <= 0; m_lives <= 3; m_pulse <= 1'b0; m_over <= 1'b0;
    end else if (state == 4'b0100) begin
      m_pulse <= 1'b0;
      if (btnC && m_mode != M_IDLE && m_mode != M_OVER) begin
        m_mode <= M_OVER; m_fe <= '0; m_over <= 1'b1; m_age <= 0;
      end else begin
        case (m_mode)
          M_IDLE: m_mode <= M_PICK;
          M_PICK: begin
            m_kind <= int'(raw_mic_data) % 3; m_age <= 0; m_fe <= '0; m_mode <= M_SHOW;
          end
          M_SHOW: begin
            if (int'(frequency) > 450) begin
              m_fe <= 6'(1 << (2 * m_kind + 1));
              m_score <= (m_score < WIN) ? m_score + 1 : WIN;
              m_pulse <= 1'b1; m_age <= 0; m_mode <= M_SLICED;
            end else begin
              m_fe <= 6'(1 << (2 * m_kind));
              if (m_age + 1 == SHOW) begin m_age <= 0; m_mode <= M_MISS; end
              else m_age <= m_age + 1;
            end
          end
          M_SLICED: begin
            if (m_age + 1 == SLICED) begin
              m_age <= 0;
              if (m_score == WIN) begin m_mode <= M_OVER; m_fe <= '0; m_over <= 1'b1; end
              else m_mode <= M_PICK;
            end else m_age <= m_age + 1;
          end
          M_MISS: begin
            m_fe <= '0;
            m_lives <= (m_lives > 0) ? m_lives - 1 : 0;
            if (m_lives <= 1) begin m_mode <= M_OVER; m_over <= 1'b1; end
            else m_mode <= M_PICK;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({fruit_en, score, lives, slice_pulse, game_over} !==
        {m_fe, 7'(m_score), 2'(m_lives), m_pulse, m_over}) begin
      errors++;
      $display("FAIL model t=%0t actual fe=%b score=%0d lives=%0d pulse=%b over=%b required fe=%b score=%0d lives=%0d pulse=%b over=%b",
               $time, fruit_en, score, lives, slice_pulse, game_over,
               m_fe, m_score, m_lives, m_pulse, m_over);
    end
    checks++;
    if (!$onehot0(fruit_en)) begin
      errors++;
      $display("FAIL onehot t=%0t actual fe=%b required at most one bit set", $time, fruit_en);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; state = 4'b0000; btnC = 1'b0; frequency = 12'd0; raw_mic_data = 12'd0;
    step(2);
    chk("rst_fe", fruit_en, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_over", game_over, 0);
    chk("rst_pulse", slice_pulse, 0);
    rst_n = 1'b1;

    // Banana left unsliced: visible for 8 ticks, then a life is lost.
    state = 4'b0100; raw_mic_data = 12'd4; frequency = 12'd100;
    step(2);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (fruit_en == 6'b000100) cnt++;
    end
    chk("miss_visible_cycles", cnt, 8);
    chk("miss_lives", lives, 2);
    chk("miss_fe_clear", fruit_en, 0);
    step(20);
    chk("three_miss_lives", lives, 0);
    chk("three_miss_over", game_over, 1);
    step(5);
    chk("over_hold_over", game_over, 1);
    chk("over_hold_fe", fruit_en, 0);
    state = 4'b0000;
    step();
    chk("menu_over", game_over, 0);
    chk("menu_lives", lives, 3);

    // Melon sliced on the third SHOW tick; frequency held high through the hold.
    state = 4'b0100; raw_mic_data = 12'd3;
    step(3);
    chk("melon_fe", fruit_en, 6'b000001);
    step();
    frequency = 12'd500;
    step();
    chk("slice_fe", fruit_en, 6'b000010);
    chk("slice_score", score, 1);
    chk("slice_pulse", slice_pulse, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_score", score, 1);
      chk("hold_pulse", slice_pulse, 0);
    end
    frequency = 12'd100;

    // Asynchronous reset in the middle of a SHOW window.
    step(2);
    chk("pre_rst_score", score, 1);
    chk("pre_rst_fe", fruit_en, 6'b000001);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_fe", fruit_en, 0);
    chk("async_rst_score", score, 0);
    chk("async_rst_lives", lives, 3);
    step();
    rst_n = 1'b1;

    // Slice on the last SHOW tick beats the timeout.
    step(2);
    step(7);
    frequency = 12'd500;
    step();
    chk("late_slice_fe", fruit_en, 6'b000010);
    chk("late_slice_score", score, 1);
    chk("late_slice_lives", lives, 3);
    chk("late_slice_pulse", slice_pulse, 1);
    frequency = 12'd100;
    step(4);

    // Quit request and slice in the same tick: quit wins.
    step(2);
    frequency = 12'd500; btnC = 1'b1;
    step();
    chk("quit_over", game_over, 1);
    chk("quit_score", score, 1);
    chk("quit_fe", fruit_en, 0);
    chk("quit_pulse", slice_pulse, 0);
    btnC = 1'b0; frequency = 12'd100;
    step();
    chk("quit_hold", game_over, 1);
    state = 4'b0000;
    step();

    // Freeze mid-SHOW: timer and outputs hold, slice and quit ignored.
    state = 4'b0100; raw_mic_data = 12'd3;
    step(5);
    state = 4'b0010; frequency = 12'd500; btnC = 1'b1;
    step(5);
    chk("freeze_fe", fruit_en, 6'b000001);
    chk("freeze_score", score, 0);
    chk("freeze_over", game_over, 0);
    state = 4'b0100; frequency = 12'd100; btnC = 1'b0;
    step(5);
    chk("resume_lives", lives, 3);
    chk("resume_fe", fruit_en, 6'b000001);
    step();
    chk("resume_miss_lives", lives, 2);
    state = 4'b0000;
    step();

    // Slice every berry until the winning score, then the hold ends the game.
    state = 4'b0100; raw_mic_data = 12'd5; frequency = 12'd500;
    for (int i = 0; i < 1000 && score != 7'd99; i++) step();
    chk("win_score", score, 99);
    chk("win_fe", fruit_en, 6'b100000);
    step(3);
    chk("win_hold_over", game_over, 0);
    chk("win_hold_fe", fruit_en, 6'b100000);
    step();
    chk("win_over", game_over, 1);
    chk("win_over_fe", fruit_en, 0);
    step(5);
    chk("win_score_stays", score, 99);
    state = 4'b0000;
    step();
    chk("final_clear", score, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
